conv_axis_stream_ctrl: RTL and testbench
========================================

CONV_AXIS_STREAM_CTRL -- requirements
Module: conv_axis_stream_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 8, fmap/weight element width; ACC_W, 32, output element width; CIN, 3, input channels; H_IN, 112, input height; W_IN, 112, input width; COUT, 64, output channels; KH, 7, kernel height; KW, 7, kernel width; H_OUT, 56, output height; W_OUT, 56, output width.
REQ-002 Derived totals: FMAP_TOTAL=CIN*H_IN*W_IN, WT_TOTAL=COUT*CIN*KH*KW, OUT_TOTAL=COUT*H_OUT*W_OUT; address widths = $clog2 of each total.
REQ-003 Ports (name direction width meaning): clk in 1 clock; rst in 1 reset; start in 1 job request; done out 1 job-complete pulse; busy out 1 job in progress; err out 1 sticky tlast-framing error.
REQ-004 s_axis_fmap_{tvalid in 1, tready out 1, tdata in DATA_W signed, tlast in 1}; s_axis_weight_{same, DATA_W signed}; m_axis_out_{tvalid out 1, tready in 1, tdata out ACC_W signed, tlast out 1}.
REQ-005 Engine port: eng_start out 1; eng_done in 1; eng_fmap_raddr in FMAP_AW, eng_fmap_rdata out DATA_W; eng_wt_raddr in WT_AW, eng_wt_rdata out DATA_W; eng_out_we in 1, eng_out_waddr in OUT_AW, eng_out_wdata in ACC_W.
REQ-006 One clock, clk; reset is asynchronous and active-high, port rst.

Function
REQ-007 States IDLE, LOAD, RUN, DUMP, DONE; flat linear addressing, no divide/modulo.
REQ-008 IDLE: start=1 -> LOAD; counters cleared, err cleared. start outside IDLE is ignored.
REQ-009 LOAD: fmap and weight streams accepted concurrently and independently; each tready=1 while its count < its total, 0 once complete.
REQ-010 Each accepted beat writes the buffer at address = beat count, count+1.
REQ-011 tlast check: tlast must be 1 on beat TOTAL-1 and 0 otherwise; any mismatch sets err (sticky until next start); data still stored, count unaffected.
REQ-012 LOAD -> RUN in the cycle after both counts reach their totals (both complete in the same cycle included); eng_start=1 for exactly one cycle on RUN entry.
REQ-013 RUN: fmap/weight buffers are synchronous-read, rdata valid 1 cycle after raddr; eng_out_we writes out buffer; eng_done=1 -> DUMP.
REQ-014 DUMP: out buffer read sequentially 0..OUT_TOTAL-1 via a 1-cycle read into a registered output stage; first tvalid 2 cycles after DUMP entry.
REQ-015 Output stage holds tdata/tlast stable while tvalid=1 and tready=0; with tready held 1, one beat per cycle (prefetch next address during transfer).
REQ-016 m_axis_out_tlast=1 only on beat OUT_TOTAL-1; after that transfer -> DONE.
REQ-017 DONE: done=1 for one cycle, then IDLE; new start accepted in the following cycle.
REQ-018 busy=1 in LOAD, RUN, DUMP, DONE.
REQ-019 Buffer writes only from the AXIS inputs (LOAD) and eng_out_we (RUN); eng_out_we in other states ignored.

Reset
REQ-020 rst=1 asynchronously forces IDLE; counters 0; done, busy, err, eng_start, all tready, m_axis_out_tvalid, m_axis_out_tlast = 0; m_axis_out_tdata = 0.
REQ-021 Reset mid-job abandons the job; buffer contents are not cleared and are undefined for the next job until reloaded.

Structure
REQ-022 State enum and DATA_W/ACC_W defaults in backbone_pkg; geometry parameters stay module parameters.
REQ-023 One sub-module, conv_sp_ram (parametrised width/depth, 1 write port, 1 synchronous read port), instantiated three times for fmap, weight and out buffers.

Verification
REQ-024 Bench geometry CIN=1, H_IN=W_IN=4, COUT=2, KH=KW=3, H_OUT=W_OUT=2 (FMAP 16, WT 18, OUT 8); engine model writes out[i]=i*3-5.
REQ-025 Concurrent load: fmap 0..15 and weight 100..117 interleaved with random tvalid gaps -> single eng_start pulse after beat 18; engine reads fmap[5]=5, weight[17]=117.
REQ-026 Dump under backpressure: tready toggled 1,0,0,1... -> 8 beats -5,-2,1,...,16, tlast on beat 7 only, data stable while stalled, then done pulse, busy=0.
REQ-027 Framing error: fmap tlast on beat 14 -> err=1 after that beat, job still completes; next start clears err.
REQ-028 Reset mid-LOAD after 7 fmap beats -> all outputs at reset values the same cycle; restarted job with full reload completes correctly.
REQ-029 start pulsed during DUMP -> ignored; done pulses once; back-to-back job started the cycle after done completes with correct output.

Source files
------------

// File: rtl/backbone_pkg.sv
// Shared types and default element widths for the convolution stream controller.
package backbone_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv_sp_ram.sv
// Simple dual-address RAM: one write port, one registered read port with enable.
module conv_sp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read data holds while re=0 so a stalled consumer can come back for it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_axis_stream_ctrl.sv
// Loads fmap/weight buffers from AXI-Stream, hands them to a compute engine,
// then streams the engine's output buffer back out over AXI-Stream.
module conv_axis_stream_ctrl
  import backbone_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CIN    = 3,
  parameter int H_IN   = 112,
  parameter int W_IN   = 112,
  parameter int COUT   = 64,
  parameter int KH     = 7,
  parameter int KW     = 7,
  parameter int H_OUT  = 56,
  parameter int W_OUT  = 56,
  localparam int FMAP_TOTAL = CIN * H_IN * W_IN,
  localparam int WT_TOTAL   = COUT * CIN * KH * KW,
  localparam int OUT_TOTAL  = COUT * H_OUT * W_OUT,
  localparam int FMAP_AW    = $clog2(FMAP_TOTAL),
  localparam int WT_AW      = $clog2(WT_TOTAL),
  localparam int OUT_AW     = $clog2(OUT_TOTAL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     done,
  output logic                     busy,
  output logic                     err,

  input  logic                     s_axis_fmap_tvalid,
  output logic                     s_axis_fmap_tready,
  input  logic signed [DATA_W-1:0] s_axis_fmap_tdata,
  input  logic                     s_axis_fmap_tlast,

  input  logic                     s_axis_weight_tvalid,
  output logic                     s_axis_weight_tready,
  input  logic signed [DATA_W-1:0] s_axis_weight_tdata,
  input  logic                     s_axis_weight_tlast,

  output logic                     m_axis_out_tvalid,
  input  logic                     m_axis_out_tready,
  output logic signed [ACC_W-1:0]  m_axis_out_tdata,
  output logic                     m_axis_out_tlast,

  output logic                     eng_start,
  input  logic                     eng_done,
  input  logic [FMAP_AW-1:0]       eng_fmap_raddr,
  output logic [DATA_W-1:0]        eng_fmap_rdata,
  input  logic [WT_AW-1:0]         eng_wt_raddr,
  output logic [DATA_W-1:0]        eng_wt_rdata,
  input  logic                     eng_out_we,
  input  logic [OUT_AW-1:0]        eng_out_waddr,
  input  logic [ACC_W-1:0]         eng_out_wdata
);

  // Counters carry one extra bit so they can sit at the full total.
  localparam int FCW = FMAP_AW + 1;
  localparam int WCW = WT_AW + 1;
  localparam int OCW = OUT_AW + 1;

  localparam logic [FCW-1:0] FMAP_END  = FCW'(FMAP_TOTAL);
  localparam logic [FCW-1:0] FMAP_LAST = FCW'(FMAP_TOTAL - 1);
  localparam logic [WCW-1:0] WT_END    = WCW'(WT_TOTAL);
  localparam logic [WCW-1:0] WT_LAST   = WCW'(WT_TOTAL - 1);
  localparam logic [OCW-1:0] OUT_END   = OCW'(OUT_TOTAL);
  localparam logic [OCW-1:0] OUT_LAST  = OCW'(OUT_TOTAL - 1);

  state_e             state_q, state_d;
  logic [FCW-1:0]     fmap_cnt_q, fmap_cnt_d;
  logic [WCW-1:0]     wt_cnt_q, wt_cnt_d;
  logic [OCW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [OCW-1:0]     ld_cnt_q, ld_cnt_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               eng_start_q, eng_start_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic [ACC_W-1:0]   tdata_q, tdata_d;

  logic               fmap_fire;
  logic               wt_fire;
  logic               out_we;
  logic               out_fire;
  logic               out_load;
  logic               out_issue;
  logic [ACC_W-1:0]   out_rdata;

  assign s_axis_fmap_tready   = (state_q == ST_LOAD) && (fmap_cnt_q < FMAP_END);
  assign s_axis_weight_tready = (state_q == ST_LOAD) && (wt_cnt_q < WT_END);
  assign fmap_fire = s_axis_fmap_tready && s_axis_fmap_tvalid;
  assign wt_fire   = s_axis_weight_tready && s_axis_weight_tvalid;
  assign out_we    = (state_q == ST_RUN) && eng_out_we;

  // Dump pipeline: pend_q marks unconsumed data sitting on the RAM read port.
  // A new read is issued only when that slot will be free next cycle.
  assign out_fire  = tvalid_q && m_axis_out_tready;
  assign out_load  = (state_q == ST_DUMP) && pend_q && (!tvalid_q || m_axis_out_tready);
  assign out_issue = (state_q == ST_DUMP) && (rd_cnt_q < OUT_END) && (!pend_q || out_load);

  assign done              = (state_q == ST_DONE);
  assign busy              = (state_q != ST_IDLE);
  assign err               = err_q;
  assign eng_start         = eng_start_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign m_axis_out_tlast  = tlast_q;
  assign m_axis_out_tdata  = tdata_q;

  conv_sp_ram #(.WIDTH(DATA_W), .DEPTH(FMAP_TOTAL)) u_fmap_ram (
    .clk   (clk),
    .we    (fmap_fire),
    .waddr (fmap_cnt_q[FMAP_AW-1:0]),
    .wdata (s_axis_fmap_tdata),
    .re    (1'b1),
    .raddr (eng_fmap_raddr),
    .rdata (eng_fmap_rdata)
  );

  conv_sp_ram #(.WIDTH(DATA_W), .DEPTH(WT_TOTAL)) u_wt_ram (
    .clk   (clk),
    .we    (wt_fire),
    .waddr (wt_cnt_q[WT_AW-1:0]),
    .wdata (s_axis_weight_tdata),
    .re    (1'b1),
    .raddr (eng_wt_raddr),
    .rdata (eng_wt_rdata)
  );

  conv_sp_ram #(.WIDTH(ACC_W), .DEPTH(OUT_TOTAL)) u_out_ram (
    .clk   (clk),
    .we    (out_we),
    .waddr (eng_out_waddr),
    .wdata (eng_out_wdata),
    .re    (out_issue),
    .raddr (rd_cnt_q[OUT_AW-1:0]),
    .rdata (out_rdata)
  );

  always_comb begin
    state_d     = state_q;
    fmap_cnt_d  = fmap_cnt_q;
    wt_cnt_d    = wt_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    pend_d      = pend_q;
    err_d       = err_q;
    eng_start_d = 1'b0;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          fmap_cnt_d = '0;
          wt_cnt_d   = '0;
          rd_cnt_d   = '0;
          ld_cnt_d   = '0;
          pend_d     = 1'b0;
          err_d      = 1'b0;
        end
      end

      ST_LOAD: begin
        // A framing error is flagged but the beat is still stored and counted.
        if (fmap_fire) begin
          fmap_cnt_d = fmap_cnt_q + FCW'(1);
          if (s_axis_fmap_tlast != (fmap_cnt_q == FMAP_LAST)) err_d = 1'b1;
        end
        if (wt_fire) begin
          wt_cnt_d = wt_cnt_q + WCW'(1);
          if (s_axis_weight_tlast != (wt_cnt_q == WT_LAST)) err_d = 1'b1;
        end
        if ((fmap_cnt_q == FMAP_END) && (wt_cnt_q == WT_END)) begin
          state_d     = ST_RUN;
          eng_start_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (eng_done) state_d = ST_DUMP;
      end

      ST_DUMP: begin
        if (out_issue) rd_cnt_d = rd_cnt_q + OCW'(1);
        if (out_issue) pend_d = 1'b1;
        else if (out_load) pend_d = 1'b0;

        if (out_load) begin
          tvalid_d = 1'b1;
          tdata_d  = out_rdata;
          tlast_d  = (ld_cnt_q == OUT_LAST);
          ld_cnt_d = ld_cnt_q + OCW'(1);
        end else if (out_fire) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end

        if (out_fire && tlast_q) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fmap_cnt_q  <= '0;
      wt_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      ld_cnt_q    <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      fmap_cnt_q  <= fmap_cnt_d;
      wt_cnt_q    <= wt_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
    end
  end

endmodule

// File: tb/tb_conv_axis_stream_ctrl.sv
// Job-level bench: table of jobs driven through load/run/dump against reference arrays.
module tb_conv_axis_stream_ctrl;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int FMAP_T = 16;
  localparam int WT_T   = 18;
  localparam int OUT_T  = 8;
  localparam int FMAP_AW = 4;
  localparam int WT_AW   = 5;
  localparam int OUT_AW  = 3;

  logic clk = 1'b0;
  logic rst, start, done, busy, err;
  logic s_axis_fmap_tvalid, s_axis_fmap_tready, s_axis_fmap_tlast;
  logic signed [DATA_W-1:0] s_axis_fmap_tdata;
  logic s_axis_weight_tvalid, s_axis_weight_tready, s_axis_weight_tlast;
  logic signed [DATA_W-1:0] s_axis_weight_tdata;
  logic m_axis_out_tvalid, m_axis_out_tready, m_axis_out_tlast;
  logic signed [ACC_W-1:0] m_axis_out_tdata;
  logic eng_start, eng_done, eng_out_we;
  logic [FMAP_AW-1:0] eng_fmap_raddr;
  logic [DATA_W-1:0]  eng_fmap_rdata;
  logic [WT_AW-1:0]   eng_wt_raddr;
  logic [DATA_W-1:0]  eng_wt_rdata;
  logic [OUT_AW-1:0]  eng_out_waddr;
  logic [ACC_W-1:0]   eng_out_wdata;

  conv_axis_stream_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .CIN(1), .H_IN(4), .W_IN(4), .COUT(2),
    .KH(3), .KW(3), .H_OUT(2), .W_OUT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy), .err(err),
    .s_axis_fmap_tvalid(s_axis_fmap_tvalid), .s_axis_fmap_tready(s_axis_fmap_tready),
    .s_axis_fmap_tdata(s_axis_fmap_tdata), .s_axis_fmap_tlast(s_axis_fmap_tlast),
    .s_axis_weight_tvalid(s_axis_weight_tvalid), .s_axis_weight_tready(s_axis_weight_tready),
    .s_axis_weight_tdata(s_axis_weight_tdata), .s_axis_weight_tlast(s_axis_weight_tlast),
    .m_axis_out_tvalid(m_axis_out_tvalid), .m_axis_out_tready(m_axis_out_tready),
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tlast(m_axis_out_tlast),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_fmap_raddr(eng_fmap_raddr), .eng_fmap_rdata(eng_fmap_rdata),
    .eng_wt_raddr(eng_wt_raddr), .eng_wt_rdata(eng_wt_rdata),
    .eng_out_we(eng_out_we), .eng_out_waddr(eng_out_waddr), .eng_out_wdata(eng_out_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit spec_data;
    int fmap_bad;
    int wt_bad;
    int bp_mode;
    int gap_pct;
    bit exp_err;
  } job_t;

  job_t jobs [6];
  logic signed [DATA_W-1:0] fmap_ref [FMAP_T];
  logic signed [DATA_W-1:0] wt_ref   [WT_T];
  logic signed [ACC_W-1:0]  out_ref  [OUT_T];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic send_fmap(input int n, input int bad, input int gap);
    for (int b = 0; b < n; b++) begin
      int w;
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gap; g++) begin
        s_axis_fmap_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_fmap_tvalid = 1'b1;
      s_axis_fmap_tdata  = fmap_ref[b];
      s_axis_fmap_tlast  = (b == FMAP_T - 1) ^ (b == bad);
      w = 0;
      while (!s_axis_fmap_tready && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (!s_axis_fmap_tready) begin
        check("fmap_tready_timeout", s_axis_fmap_tready, 1);
        break;
      end
      @(posedge clk); #1;
      if (b == bad) check("err_after_bad_fmap_beat", err, 1);
    end
    s_axis_fmap_tvalid = 1'b0;
    s_axis_fmap_tlast  = 1'b0;
  endtask

  task automatic send_wt(input int n, input int bad, input int gap);
    for (int b = 0; b < n; b++) begin
      int w;
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gap; g++) begin
        s_axis_weight_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_weight_tvalid = 1'b1;
      s_axis_weight_tdata  = wt_ref[b];
      s_axis_weight_tlast  = (b == WT_T - 1) ^ (b == bad);
      w = 0;
      while (!s_axis_weight_tready && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (!s_axis_weight_tready) begin
        check("wt_tready_timeout", s_axis_weight_tready, 1);
        break;
      end
      @(posedge clk); #1;
      if (b == bad) check("err_after_bad_wt_beat", err, 1);
    end
    s_axis_weight_tvalid = 1'b0;
    s_axis_weight_tlast  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_eng_start"}, eng_start, 0);
    check({tag, "_fmap_tready"}, s_axis_fmap_tready, 0);
    check({tag, "_wt_tready"}, s_axis_weight_tready, 0);
    check({tag, "_tvalid"}, m_axis_out_tvalid, 0);
    check({tag, "_tlast"}, m_axis_out_tlast, 0);
    check({tag, "_tdata"}, m_axis_out_tdata, 0);
  endtask

  task automatic run_job(input job_t jb, input int id);
    int beat, cyc, first_cyc;
    bit stalled;
    logic signed [ACC_W-1:0] held_d;
    logic held_l;
    for (int b = 0; b < FMAP_T; b++) fmap_ref[b] = jb.spec_data ? 8'(b) : 8'($urandom);
    for (int b = 0; b < WT_T; b++)   wt_ref[b]   = jb.spec_data ? 8'(100 + b) : 8'($urandom);
    for (int i = 0; i < OUT_T; i++)  out_ref[i]  = jb.spec_data ? 32'(i * 3 - 5) : 32'($urandom);
    done_cnt = 0;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_clears_err", err, 0);
    check("load_fmap_tready", s_axis_fmap_tready, 1);
    check("load_wt_tready", s_axis_weight_tready, 1);

    fork
      send_fmap(FMAP_T, jb.fmap_bad, jb.gap_pct);
      send_wt(WT_T, jb.wt_bad, jb.gap_pct);
    join
    check("eng_start_not_early", eng_start, 0);
    check("fmap_tready_full", s_axis_fmap_tready, 0);
    check("wt_tready_full", s_axis_weight_tready, 0);

    @(posedge clk); #1;
    check("eng_start_pulse", eng_start, 1);
    eng_fmap_raddr = 4'd5;
    eng_wt_raddr   = 5'd17;
    @(posedge clk); #1;
    check("eng_start_one_cycle", eng_start, 0);
    check("eng_fmap_rd5", $signed(eng_fmap_rdata), fmap_ref[5]);
    check("eng_wt_rd17", $signed(eng_wt_rdata), wt_ref[17]);
    for (int k = 0; k < 2; k++) begin
      eng_fmap_raddr = 4'($urandom_range(0, FMAP_T - 1));
      eng_wt_raddr   = 5'($urandom_range(0, WT_T - 1));
      @(posedge clk); #1;
      check("eng_fmap_rd_rand", $signed(eng_fmap_rdata), fmap_ref[eng_fmap_raddr]);
      check("eng_wt_rd_rand", $signed(eng_wt_rdata), wt_ref[eng_wt_raddr]);
    end
    for (int i = 0; i < OUT_T; i++) begin
      eng_out_we    = 1'b1;
      eng_out_waddr = 3'(i);
      eng_out_wdata = out_ref[i];
      @(posedge clk); #1;
    end
    eng_out_we = 1'b0;
    eng_done   = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;

    beat = 0; cyc = 0; first_cyc = -1; stalled = 0;
    held_d = '0; held_l = 1'b0;
    while (beat < OUT_T && cyc < 100) begin
      case (jb.bp_mode)
        0:       m_axis_out_tready = 1'b1;
        1:       m_axis_out_tready = (cyc % 3 == 0);
        default: m_axis_out_tready = 1'($urandom_range(0, 1));
      endcase
      eng_out_we    = (cyc == 0);
      eng_out_waddr = 3'(OUT_T - 1);
      eng_out_wdata = 32'h5a5a_0000;
      start         = (cyc == 3);
      if (m_axis_out_tvalid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check("first_tvalid_latency", cyc, 2);
        end
        if (stalled) begin
          check("stall_tdata_stable", m_axis_out_tdata, held_d);
          check("stall_tlast_stable", m_axis_out_tlast, held_l);
        end
        if (m_axis_out_tready) begin
          check("dump_tdata", m_axis_out_tdata, out_ref[beat]);
          check("dump_tlast", m_axis_out_tlast, beat == OUT_T - 1);
          beat++;
          stalled = 0;
        end else begin
          held_d  = m_axis_out_tdata;
          held_l  = m_axis_out_tlast;
          stalled = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    eng_out_we = 1'b0;
    start      = 1'b0;
    m_axis_out_tready = 1'b0;
    check("dump_beats", beat, OUT_T);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_tvalid", m_axis_out_tvalid, 0);
    check("job_err", err, jb.exp_err);
    check("done_count", done_cnt, 1);
    $display("[TB] job %0d complete: %0d beats in %0d cycles, err=%0b", id, beat, cyc, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    job_t rj;
    rst = 1'b0; start = 1'b0;
    s_axis_fmap_tvalid = 1'b0; s_axis_fmap_tdata = '0; s_axis_fmap_tlast = 1'b0;
    s_axis_weight_tvalid = 1'b0; s_axis_weight_tdata = '0; s_axis_weight_tlast = 1'b0;
    m_axis_out_tready = 1'b0; eng_done = 1'b0; eng_out_we = 1'b0;
    eng_fmap_raddr = '0; eng_wt_raddr = '0; eng_out_waddr = '0; eng_out_wdata = '0;
    #1 rst = 1'b1;
    #11;
    check_reset_values("por");
    @(posedge clk); #1;
    rst = 1'b0;

    jobs[0] = '{1'b1, -1, -1, 1, 40, 1'b0};
    jobs[1] = '{1'b1, 14, -1, 0, 20, 1'b1};
    jobs[2] = '{1'b0, -1, -1, 2, 50, 1'b0};
    jobs[3] = '{1'b0, -1, 17, 2, 30, 1'b1};
    jobs[4] = '{1'b0,  0, -1, 1, 10, 1'b1};
    jobs[5] = '{1'b0, -1, -1, 0,  0, 1'b0};
    for (int j = 0; j < 6; j++) run_job(jobs[j], j);

    // Reset in the middle of a load that has already flagged a framing error.
    for (int b = 0; b < FMAP_T; b++) fmap_ref[b] = 8'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_fmap(7, 3, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_values("mid_load_rst");
    $display("[TB] reset asserted after 7 fmap beats");
    @(posedge clk); #1;
    rst = 1'b0;
    rj = '{1'b1, -1, -1, 1, 25, 1'b0};
    run_job(rj, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
